// File: rtl/cnn_param_pkg.sv
// Shared parameter-image layout for the CNN datapath.
//
// The weight ROM holds one contiguous byte image. Each layer engine slices
// its segment out of the flat parameter bus using the offsets below:
//   byte k of the image sits at param_bus[k*8 +: 8].
// Layout: a short image header, then for each of two depthwise-separable
// layers the dconv weights/bias/shift followed by the pconv weights/bias/shift.
// Also holds the loader state encoding shared by the loader and its users.
package cnn_param_pkg;

    // Channel counts of the two separable layers.
    localparam int C_IN  = 8;
    localparam int C_MID = 16;
    localparam int C_OUT = 8;
    localparam int KSIZE = 9;  // 3x3 depthwise kernel

    // Image header: magic, version, layer count, two reserved bytes.
    localparam int HDR_OFF = 0;
    localparam int HDR_LEN = 5;

    // Layer 0 depthwise
    localparam int L0_DW_W_OFF = HDR_OFF + HDR_LEN;
    localparam int L0_DW_W_LEN = KSIZE * C_IN;
    localparam int L0_DW_B_OFF = L0_DW_W_OFF + L0_DW_W_LEN;
    localparam int L0_DW_B_LEN = C_IN;
    localparam int L0_DW_S_OFF = L0_DW_B_OFF + L0_DW_B_LEN;
    localparam int L0_DW_S_LEN = 1;
    // Layer 0 pointwise
    localparam int L0_PW_W_OFF = L0_DW_S_OFF + L0_DW_S_LEN;
    localparam int L0_PW_W_LEN = C_IN * C_MID;
    localparam int L0_PW_B_OFF = L0_PW_W_OFF + L0_PW_W_LEN;
    localparam int L0_PW_B_LEN = C_MID;
    localparam int L0_PW_S_OFF = L0_PW_B_OFF + L0_PW_B_LEN;
    localparam int L0_PW_S_LEN = 1;
    // Layer 1 depthwise
    localparam int L1_DW_W_OFF = L0_PW_S_OFF + L0_PW_S_LEN;
    localparam int L1_DW_W_LEN = KSIZE * C_MID;
    localparam int L1_DW_B_OFF = L1_DW_W_OFF + L1_DW_W_LEN;
    localparam int L1_DW_B_LEN = C_MID;
    localparam int L1_DW_S_OFF = L1_DW_B_OFF + L1_DW_B_LEN;
    localparam int L1_DW_S_LEN = 1;
    // Layer 1 pointwise
    localparam int L1_PW_W_OFF = L1_DW_S_OFF + L1_DW_S_LEN;
    localparam int L1_PW_W_LEN = C_MID * C_OUT;
    localparam int L1_PW_B_OFF = L1_PW_W_OFF + L1_PW_W_LEN;
    localparam int L1_PW_B_LEN = C_OUT;
    localparam int L1_PW_S_OFF = L1_PW_B_OFF + L1_PW_B_LEN;
    localparam int L1_PW_S_LEN = 1;

    // Payload length (checksum byte excluded): 529 for the default layout.
    localparam int TOTAL_BYTES = L1_PW_S_OFF + L1_PW_S_LEN;

    // Bit position of a segment's first byte on a bus of byte lanes lane_w wide.
    function automatic int seg_lsb(input int byte_off, input int lane_w);
        return byte_off * lane_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/param_rd_pipe.sv
// ROM read tracking delay line for param_loader.
//
// Delays {valid, index} by exactly LATENCY cycles so each entry leaves the
// line in the same cycle the ROM presents the data for that index.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_idx     read issued this cycle and its byte index
//   out_valid, out_idx   entry whose ROM data is on rom_dout this cycle
//   inflight             an entry will still be present next cycle even with
//                        no new issue (any valid stage other than the exit)
module param_rd_pipe #(
    parameter int LATENCY = 2,
    parameter int IDX_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             inflight
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q [LATENCY];
    logic [IDX_W-1:0]   idx_d [LATENCY];

    // NOTE: every signal written in always_comb gets a value on all paths
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the index shift has no reset; it is qualified by valid_q, and
    // leaving data storage unreset keeps the reset tree small.
    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            inflight = inflight | valid_q[i];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/param_loader.sv
// Streams the parameter image out of a synchronous weight ROM and packs it
// into one flat bus sliced by the layer engines (see cnn_param_pkg offsets).
//
// Optional feature macro: PARAM_LOADER_CHECKSUM_EN
//   defined   -> one extra ROM byte (address TOTAL_BYTES) holds the two's
//                complement of the payload sum; a CHECK state flags chk_err.
//   undefined -> no extra fetch, no CHECK state, chk_err tied low.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       load/reload request (pulse or level), honoured in IDLE/DONE
//   rom_en      ROM read enable (high while fetching)
//   rom_addr    ROM read address (issue counter)
//   rom_dout    ROM data, ROM_LATENCY cycles after the address
//   param_bus   packed image, byte k at [k*DATA_W +: DATA_W]
//   busy        load in progress (FETCH, DRAIN, CHECK)
//   done        image complete and frozen
//   chk_err     checksum mismatch of the last load
module param_loader #(
    parameter int TOTAL_BYTES = cnn_param_pkg::TOTAL_BYTES,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int ROM_LATENCY = 2,
    parameter int AUTO_START  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          rom_en,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_dout,
    output logic [TOTAL_BYTES*DATA_W-1:0] param_bus,
    output logic                          busy,
    output logic                          done,
    output logic                          chk_err
);
    import cnn_param_pkg::*;

`ifdef PARAM_LOADER_CHECKSUM_EN
    localparam int N_FETCH = TOTAL_BYTES + 1;
`else
    localparam int N_FETCH = TOTAL_BYTES;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FETCH - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(TOTAL_BYTES - 1);

    ld_state_e                     state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          auto_q, auto_d;
    logic [TOTAL_BYTES*DATA_W-1:0] bus_q, bus_d;
    logic                          fetch_entry;

    logic                          cap_valid;
    logic [ADDR_W-1:0]             cap_idx;
    logic                          inflight;

    assign rom_en = (state_q == ST_FETCH);

    param_rd_pipe #(
        .LATENCY (ROM_LATENCY),
        .IDX_W   (ADDR_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rom_en),
        .in_idx    (addr_q),
        .out_valid (cap_valid),
        .out_idx   (cap_idx),
        .inflight  (inflight)
    );

    // Next-state logic. auto_q stands in for a start request on the first
    // cycle out of reset when AUTO_START is set.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        auto_d      = auto_q;
        fetch_entry = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start || auto_q) fetch_entry = 1'b1;
            end
            ST_FETCH: begin
                // Address holds at the last issued value once fetching ends.
                if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                else                     addr_d  = addr_q + ADDR_W'(1);
            end
            ST_DRAIN: begin
                // The entry leaving this cycle is written at this edge, so
                // only stages behind it keep us here.
                if (!inflight) begin
`ifdef PARAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) fetch_entry = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fetch_entry) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            auto_d  = 1'b0;
        end
    end

    // Byte write: the checksum byte (index TOTAL_BYTES) never lands on the bus.
    always_comb begin
        bus_d = bus_q;
        if (cap_valid && (cap_idx <= LAST_BYTE)) begin
            bus_d[int'(cap_idx)*DATA_W +: DATA_W] = rom_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            auto_q  <= (AUTO_START != 0);
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            auto_q  <= auto_d;
            bus_q   <= bus_d;
        end
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              chk_err_q, chk_err_d;

    // Sum of all captured bytes including the checksum byte; a good image
    // sums to zero mod 2^DATA_W.
    always_comb begin
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
        if (fetch_entry) begin
            sum_d     = '0;
            chk_err_d = 1'b0;
        end else if (cap_valid) begin
            sum_d = sum_q + rom_dout;
        end
        if (state_q == ST_CHECK) chk_err_d = (sum_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign rom_addr  = addr_q;
    assign param_bus = bus_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                       (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);

endmodule
